// File: rtl/hardware_transmitter.sv
// Serial framer: start(1), DATA_WIDTH bits MSB first, even parity, stop(0), each held BIT_PERIOD cycles.
// First start cycle follows the accepting edge when idle. A one-word buffer gives back-to-back frames; rdy = buffer empty.
module hardware_transmitter #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  vin,
    output logic                  rdy,
    output logic                  dout,
    output logic                  busy
);

    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_dat_q, buf_dat_d;
    logic                  rdy_en_q, rdy_en_d;
    logic                  dout_q, dout_d;

    logic                  accept;
    logic                  bit_end;
    logic                  load;
    logic                  take_buf;
    logic [DATA_WIDTH-1:0] load_dat;

    // rdy depends only on flops, never on vin
    assign rdy     = rdy_en_q & ~buf_full_q;
    assign accept  = vin & rdy;
    assign bit_end = (cnt_q == CW'(BIT_PERIOD - 1));
    assign dout    = dout_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        buf_full_d = buf_full_q;
        buf_dat_d  = buf_dat_q;
        rdy_en_d   = 1'b1;
        load       = 1'b0;
        take_buf   = 1'b0;
        load_dat   = buf_dat_q;
        dout_d     = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                // Idle with an empty buffer: the accepted word bypasses straight into the shifter
                if (buf_full_q) begin
                    load     = 1'b1;
                    take_buf = 1'b1;
                end else if (accept) begin
                    load     = 1'b1;
                    load_dat = din;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        state_d = PARITY;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (buf_full_q) begin
                        load     = 1'b1;
                        take_buf = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = load_dat;
            par_d   = ^load_dat;
        end

        if (take_buf) begin
            buf_full_d = 1'b0;
        end
        // Store unless this word went directly into the shifter
        if (accept && !(load && !take_buf)) begin
            buf_full_d = 1'b1;
            buf_dat_d  = din;
        end

        case (state_d)
            START:   dout_d = 1'b1;
            DATA:    dout_d = shreg_d[DATA_WIDTH-1];
            PARITY:  dout_d = par_d;
            default: dout_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            buf_full_q <= 1'b0;
            buf_dat_q  <= '0;
            rdy_en_q   <= 1'b0;
            dout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            buf_full_q <= buf_full_d;
            buf_dat_q  <= buf_dat_d;
            rdy_en_q   <= rdy_en_d;
            dout_q     <= dout_d;
        end
    end

endmodule
